// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: condition evaluation, target/link generation,
// mispredict detection, a one-entry result register and a multi-cycle upstream flush.

// Shared unsigned magnitude comparator; signed compares are derived by the caller.
module COMPARATOR_32bits (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        eq,
    output logic        lt
);
    assign eq = (a == b);
    assign lt = (a < b);
endmodule

// Protocol checks on the result register and flush window.
module branch_resolve_unit_chk (
    input logic        clk,
    input logic        rst,
    input logic        in_valid,
    input logic        in_ready,
    input logic        in_is_branch,
    input logic        in_is_jal,
    input logic        in_is_jalr,
    input logic        out_valid,
    input logic        out_ready,
    input logic        out_taken,
    input logic [31:0] out_target,
    input logic [31:0] out_link,
    input logic        out_mispredict,
    input logic        out_illegal,
    input logic        flush
);
    logic        hold_r;
    logic        taken_r;
    logic [31:0] target_r;
    logic [31:0] link_r;
    logic        mispredict_r;
    logic        illegal_r;

    // Snapshot the result whenever the consumer is stalling it.
    always_ff @(posedge clk) begin
        hold_r       <= !rst && out_valid && !out_ready;
        taken_r      <= out_taken;
        target_r     <= out_target;
        link_r       <= out_link;
        mispredict_r <= out_mispredict;
        illegal_r    <= out_illegal;
    end

    // A stalled result must not change, and the flush window must always drain input.
    always_ff @(posedge clk) begin
        if (hold_r) begin
            assert (out_valid && out_taken == taken_r && out_target == target_r &&
                    out_link == link_r && out_mispredict == mispredict_r &&
                    out_illegal == illegal_r);
        end
        if (!rst) begin
            assert (!flush || in_ready);
            assert (!in_valid || $onehot0({in_is_branch, in_is_jal, in_is_jalr}));
        end
    end
endmodule

// Branch resolution unit top.
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic        in_is_branch,
    input  logic        in_is_jal,
    input  logic        in_is_jalr,
    input  logic        in_pred_taken,
    input  logic [31:0] in_pred_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_taken,
    output logic [31:0] out_target,
    output logic [31:0] out_link,
    output logic        out_mispredict,
    output logic        out_illegal,
    output logic        flush,
    output logic [31:0] flush_pc
);
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    logic        signed_cmp_s;
    logic [31:0] cmp_a_s;
    logic [31:0] cmp_b_s;
    logic        cmp_eq_s;
    logic        cmp_lt_s;
    logic        cond_s;
    logic        illegal_s;
    logic        taken_s;
    logic [31:0] seq_pc_s;
    logic [31:0] rel_target_s;
    logic [31:0] jalr_sum_s;
    logic [31:0] target_s;
    logic        mispredict_s;
    logic        squash_s;
    logic        accept_s;
    logic        load_s;

    logic [3:0]  fcnt_r;
    logic        out_valid_r;
    logic        out_taken_r;
    logic [31:0] out_target_r;
    logic [31:0] out_link_r;
    logic        out_mispredict_r;
    logic        out_illegal_r;
    logic [31:0] flush_pc_r;

    // Flipping bit 31 on both operands maps two's-complement order onto unsigned order.
    assign signed_cmp_s = (in_funct3 == 3'b100) || (in_funct3 == 3'b101);
    assign cmp_a_s      = in_rs1 ^ {signed_cmp_s, 31'd0};
    assign cmp_b_s      = in_rs2 ^ {signed_cmp_s, 31'd0};

    COMPARATOR_32bits u_cmp (
        .a  (cmp_a_s),
        .b  (cmp_b_s),
        .eq (cmp_eq_s),
        .lt (cmp_lt_s)
    );

    // Branch condition decode from funct3; reserved codes never take.
    always_comb begin
        cond_s    = 1'b0;
        illegal_s = 1'b0;
        case (in_funct3)
            3'b000:         cond_s = cmp_eq_s;
            3'b001:         cond_s = !cmp_eq_s;
            3'b100, 3'b110: cond_s = cmp_lt_s;
            3'b101, 3'b111: cond_s = !cmp_lt_s;
            3'b010, 3'b011: begin
                cond_s    = 1'b0;
                illegal_s = in_is_branch;
            end
            default: begin
                cond_s    = 1'b0;
                illegal_s = 1'b0;
            end
        endcase
    end

    assign taken_s      = in_is_jal | in_is_jalr | (in_is_branch & cond_s);
    assign seq_pc_s     = in_pc + 32'd4;
    assign rel_target_s = in_pc + in_imm;
    assign jalr_sum_s   = in_rs1 + in_imm;

    // Resolved next PC; JALR targets are always halfword aligned.
    always_comb begin
        target_s = seq_pc_s;
        if (in_is_jalr) begin
            target_s = {jalr_sum_s[31:1], 1'b0};
        end else if (taken_s) begin
            target_s = rel_target_s;
        end else begin
            target_s = seq_pc_s;
        end
    end

    assign mispredict_s = (taken_s != in_pred_taken) |
                          (taken_s & in_pred_taken & (target_s != in_pred_target));

    // While the flush window is open every beat is wrong-path, so it is drained and dropped.
    assign squash_s = (fcnt_r != 4'd0);
    assign in_ready = squash_s | !out_valid_r | out_ready;
    assign accept_s = in_valid & in_ready;
    assign load_s   = accept_s & !squash_s;

    // Result register and flush window sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_r           <= 4'd0;
            flush_pc_r       <= 32'd0;
            out_valid_r      <= 1'b0;
            out_taken_r      <= 1'b0;
            out_target_r     <= 32'd0;
            out_link_r       <= 32'd0;
            out_mispredict_r <= 1'b0;
            out_illegal_r    <= 1'b0;
        end else begin
            if (squash_s) begin
                fcnt_r <= fcnt_r - 4'd1;
            end else if (load_s && mispredict_s) begin
                fcnt_r     <= FLUSH_LOAD;
                flush_pc_r <= target_s;
            end
            if (load_s) begin
                out_valid_r      <= 1'b1;
                out_taken_r      <= taken_s;
                out_target_r     <= target_s;
                out_link_r       <= seq_pc_s;
                out_mispredict_r <= mispredict_s;
                out_illegal_r    <= illegal_s;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out_valid      = out_valid_r;
    assign out_taken      = out_taken_r;
    assign out_target     = out_target_r;
    assign out_link       = out_link_r;
    assign out_mispredict = out_mispredict_r;
    assign out_illegal    = out_illegal_r;
    assign flush          = squash_s;
    assign flush_pc       = flush_pc_r;

    branch_resolve_unit_chk u_chk (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_is_branch   (in_is_branch),
        .in_is_jal      (in_is_jal),
        .in_is_jalr     (in_is_jalr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_taken      (out_taken),
        .out_target     (out_target),
        .out_link       (out_link),
        .out_mispredict (out_mispredict),
        .out_illegal    (out_illegal),
        .flush          (flush)
    );
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, multi-cycle sequences and
// randomized traffic, all scored against an in-bench queue model.
module tb_branch_resolve_unit;
    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_imm, in_rs1, in_rs2, in_pred_target;
    logic [2:0]  in_funct3;
    logic        in_is_branch, in_is_jal, in_is_jalr, in_pred_taken;
    logic        out_valid, out_ready, out_taken, out_mispredict, out_illegal, flush;
    logic [31:0] out_target, out_link, flush_pc;

    always #5 clk = ~clk;

    branch_resolve_unit #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_is_branch(in_is_branch), .in_is_jal(in_is_jal),
        .in_is_jalr(in_is_jalr), .in_pred_taken(in_pred_taken),
        .in_pred_target(in_pred_target), .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_target(out_target), .out_link(out_link),
        .out_mispredict(out_mispredict), .out_illegal(out_illegal),
        .flush(flush), .flush_pc(flush_pc)
    );

    typedef struct {
        logic [2:0]  f3;
        logic        br;
        logic        jal;
        logic        jalr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        pt;
        logic [31:0] ptgt;
        logic        e_taken;
        logic [31:0] e_target;
        logic        e_mis;
        logic        e_ill;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    vec_t        sbq[$];
    int          m_fcnt = 0;
    logic        m_full = 1'b0;
    logic [31:0] m_fpc = 32'd0;
    int          flush_hi = 0;
    int          pops = 0;
    int          dut_acc = 0;
    vec_t        tbl[15];
    vec_t        nop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Independent reference: native signed/unsigned compares.
    function automatic vec_t ref_model(input vec_t v);
        vec_t        r;
        logic        c;
        logic [31:0] t;
        r = v;
        c = 1'b0;
        r.e_ill = 1'b0;
        case (v.f3)
            3'd0:    c = (v.rs1 == v.rs2);
            3'd1:    c = (v.rs1 != v.rs2);
            3'd4:    c = ($signed(v.rs1) < $signed(v.rs2));
            3'd5:    c = ($signed(v.rs1) >= $signed(v.rs2));
            3'd6:    c = (v.rs1 < v.rs2);
            3'd7:    c = (v.rs1 >= v.rs2);
            default: begin c = 1'b0; r.e_ill = v.br; end
        endcase
        r.e_taken = v.jal | v.jalr | (v.br & c);
        if (v.jalr) t = (v.rs1 + v.imm) & 32'hFFFF_FFFE;
        else if (r.e_taken) t = v.pc + v.imm;
        else t = v.pc + 32'd4;
        r.e_target = t;
        r.e_mis = (r.e_taken != v.pt) || (r.e_taken && v.pt && (t != v.ptgt));
        return r;
    endfunction

    // One clock: drive, check before the edge, then advance the model after it.
    task automatic cycle(input logic v, input vec_t b, input logic ordy, input logic r);
        logic squash, m_ready, acc;
        vec_t e;
        in_valid = v; in_funct3 = b.f3; in_is_branch = b.br; in_is_jal = b.jal;
        in_is_jalr = b.jalr; in_pc = b.pc; in_imm = b.imm; in_rs1 = b.rs1; in_rs2 = b.rs2;
        in_pred_taken = b.pt; in_pred_target = b.ptgt; out_ready = ordy; rst = r;
        #3;
        squash  = (m_fcnt != 0);
        m_ready = squash || !m_full || ordy;
        chk("in_ready", in_ready, m_ready);
        chk("out_valid", out_valid, m_full);
        chk("flush", flush, squash);
        if (squash) chk("flush_pc", flush_pc, m_fpc);
        if (flush) flush_hi++;
        if (in_valid && in_ready) dut_acc++;
        if (out_valid && ordy) pops++;
        if (m_full && sbq.size() > 0) begin
            e = sbq[0];
            chk("out_taken", out_taken, e.e_taken);
            chk("out_target", out_target, e.e_target);
            chk("out_link", out_link, e.pc + 32'd4);
            chk("out_mispredict", out_mispredict, e.e_mis);
            chk("out_illegal", out_illegal, e.e_ill);
        end
        acc = v && m_ready && !r;
        @(posedge clk); #1;
        if (r) begin
            m_fcnt = 0; m_full = 1'b0; sbq.delete();
        end else begin
            if (m_full && ordy) begin
                if (sbq.size() > 0) sbq.delete(0);
                m_full = 1'b0;
            end
            if (squash) m_fcnt = m_fcnt - 1;
            else if (acc && b.e_mis) begin m_fcnt = FC; m_fpc = b.e_target; end
            if (acc && !squash) begin sbq.push_back(b); m_full = 1'b1; end
        end
    endtask

    initial begin
        vec_t b, r0;
        nop = '{default: 0};
        tbl[0]  = '{3'b100,1'b1,1'b0,1'b0,32'h100,32'h20,32'hFFFFFFFF,32'h1,1'b1,32'h120, 1'b1,32'h120,1'b0,1'b0};
        tbl[1]  = '{3'b110,1'b1,1'b0,1'b0,32'h100,32'h20,32'hFFFFFFFF,32'h1,1'b1,32'h120, 1'b0,32'h104,1'b1,1'b0};
        tbl[2]  = '{3'b000,1'b0,1'b0,1'b1,32'h200,32'h10,32'h1001,32'h0,1'b1,32'h1010, 1'b1,32'h1010,1'b0,1'b0};
        tbl[3]  = '{3'b000,1'b0,1'b0,1'b1,32'h200,32'h10,32'h1001,32'h0,1'b1,32'h1011, 1'b1,32'h1010,1'b1,1'b0};
        tbl[4]  = '{3'b000,1'b1,1'b0,1'b0,32'h300,32'h40,32'h5,32'h5,1'b0,32'h0, 1'b1,32'h340,1'b1,1'b0};
        tbl[5]  = '{3'b001,1'b1,1'b0,1'b0,32'h400,32'hFFFFFFF8,32'h5,32'h6,1'b1,32'h3F8, 1'b1,32'h3F8,1'b0,1'b0};
        tbl[6]  = '{3'b101,1'b1,1'b0,1'b0,32'h500,32'h10,32'h80000000,32'h0,1'b0,32'h0, 1'b0,32'h504,1'b0,1'b0};
        tbl[7]  = '{3'b111,1'b1,1'b0,1'b0,32'h500,32'h10,32'h80000000,32'h0,1'b0,32'h0, 1'b1,32'h510,1'b1,1'b0};
        tbl[8]  = '{3'b010,1'b1,1'b0,1'b0,32'h600,32'h8,32'h1,32'h1,1'b0,32'h0, 1'b0,32'h604,1'b0,1'b1};
        tbl[9]  = '{3'b000,1'b0,1'b1,1'b0,32'hFFFFFFF0,32'h20,32'h0,32'h0,1'b1,32'h10, 1'b1,32'h10,1'b0,1'b0};
        tbl[10] = '{3'b000,1'b0,1'b0,1'b0,32'h700,32'h0,32'h0,32'h0,1'b1,32'h700, 1'b0,32'h704,1'b1,1'b0};
        tbl[11] = '{3'b100,1'b1,1'b0,1'b0,32'h800,32'h20,32'h1,32'hFFFFFFFF,1'b1,32'h820, 1'b0,32'h804,1'b1,1'b0};
        tbl[12] = '{3'b011,1'b0,1'b0,1'b0,32'h900,32'h0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h904,1'b0,1'b0};
        tbl[13] = '{3'b101,1'b1,1'b0,1'b0,32'hA00,32'hFFFFFFE0,32'hFFFFFFFE,32'hFFFFFFFF,1'b0,32'h0, 1'b0,32'hA04,1'b0,1'b0};
        tbl[14] = '{3'b000,1'b0,1'b0,1'b1,32'hB00,32'h3,32'hFFFFFFFF,32'h0,1'b0,32'h0, 1'b1,32'h2,1'b1,1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_funct3 = 3'd0; in_is_branch = 1'b0; in_is_jal = 1'b0; in_is_jalr = 1'b0;
        in_pc = 32'd0; in_imm = 32'd0; in_rs1 = 32'd0; in_rs2 = 32'd0;
        in_pred_taken = 1'b0; in_pred_target = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_taken", out_taken, 1'b0);
        chk("rst_out_mispredict", out_mispredict, 1'b0);
        chk("rst_out_illegal", out_illegal, 1'b0);
        chk("rst_out_target", out_target, 32'd0);
        chk("rst_out_link", out_link, 32'd0);
        chk("rst_flush_pc", flush_pc, 32'd0);

        // Directed vectors, each followed by enough idle cycles to drain and close any flush.
        for (int i = 0; i < 15; i++) begin
            cycle(1'b1, tbl[i], 1'b1, 1'b0);
            repeat (3) cycle(1'b0, nop, 1'b1, 1'b0);
        end

        // Back-pressure then back-to-back throughput.
        b = '{3'b000,1'b1,1'b0,1'b0,32'h1000,32'h10,32'h7,32'h7,1'b1,32'h1010, 1'b0,32'h0,1'b0,1'b0};
        b = ref_model(b);
        cycle(1'b1, b, 1'b0, 1'b0);
        repeat (5) cycle(1'b1, b, 1'b0, 1'b0);
        dut_acc = 0;
        for (int k = 0; k < 10; k++) begin
            b.pc = 32'h2000 + 32'(k * 16);
            b.ptgt = b.pc + 32'h10;
            b = ref_model(b);
            cycle(1'b1, b, 1'b1, 1'b0);
        end
        chk("b2b_accepts", dut_acc, 32'd10);
        repeat (2) cycle(1'b0, nop, 1'b1, 1'b0);

        // Squash window: beats during flush are dropped, including a late mispredict.
        flush_hi = 0; pops = 0;
        b = '{3'b001,1'b1,1'b0,1'b0,32'h3000,32'h40,32'h1,32'h2,1'b0,32'h0, 1'b0,32'h0,1'b0,1'b0};
        cycle(1'b1, ref_model(b), 1'b1, 1'b0);
        b = '{3'b000,1'b0,1'b0,1'b0,32'h3004,32'h0,32'h0,32'h0,1'b0,32'h0, 1'b0,32'h0,1'b0,1'b0};
        cycle(1'b1, ref_model(b), 1'b1, 1'b0);
        b.pc = 32'h3008; b.pt = 1'b1; b.ptgt = 32'h5000;
        cycle(1'b1, ref_model(b), 1'b1, 1'b0);
        b.pc = 32'h300C; b.pt = 1'b0;
        cycle(1'b1, ref_model(b), 1'b1, 1'b0);
        repeat (4) cycle(1'b0, nop, 1'b1, 1'b0);
        chk("squash_flush_cycles", flush_hi, 32'd2);
        chk("squash_results", pops, 32'd2);

        // Reset during the first flush cycle.
        b = '{3'b000,1'b1,1'b0,1'b0,32'h4000,32'h80,32'h9,32'h9,1'b0,32'h0, 1'b0,32'h0,1'b0,1'b0};
        cycle(1'b1, ref_model(b), 1'b0, 1'b0);
        cycle(1'b0, nop, 1'b0, 1'b1);
        chk("midrst_flush", flush, 1'b0);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_target", out_target, 32'd0);
        chk("midrst_flush_pc", flush_pc, 32'd0);
        repeat (2) cycle(1'b0, nop, 1'b1, 1'b0);

        // Randomized traffic with random back-pressure.
        for (int n = 0; n < 3000; n++) begin
            int cls;
            b = nop;
            cls = $urandom_range(0, 3);
            b.br = (cls == 1); b.jal = (cls == 2); b.jalr = (cls == 3);
            b.f3 = 3'($urandom_range(0, 7));
            b.pc = $urandom; b.imm = $urandom; b.rs1 = $urandom;
            b.rs2 = ($urandom_range(0, 3) == 0) ? b.rs1 : $urandom;
            if ($urandom_range(0, 7) == 0) b.pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            b.pt = 1'($urandom_range(0, 1));
            r0 = ref_model(b);
            b.ptgt = ($urandom_range(0, 1) == 1) ? r0.e_target : $urandom;
            b = ref_model(b);
            cycle($urandom_range(0, 3) != 0, b, $urandom_range(0, 3) != 0, 1'b0);
        end
        repeat (4) cycle(1'b0, nop, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
